// File: rtl/flash_pkg.sv
// flash_pkg: shared types and default sizing for the flash word reader.
package flash_pkg;
  typedef enum logic [2:0] {IDLE, HIT, ISSUE, WAIT_DATA, DONE} flash_rd_state_t;
  localparam int FLASH_ADDR_W = 23;
  localparam int FLASH_DATA_W = 32;
  localparam int FLASH_TIMEOUT_DEF = 255;
endpackage

// File: rtl/flash_word_reader.sv
// flash_word_reader: Avalon-MM read master with a one-word cache and read timeout.
module flash_word_reader
  import flash_pkg::*;
#(
  parameter int ADDR_W = FLASH_ADDR_W,
  parameter int DATA_W = FLASH_DATA_W,
  parameter int TIMEOUT_CYCLES = FLASH_TIMEOUT_DEF
) (
  input  logic                  fetch_clock,
  input  logic                  reset,
  input  logic                  word_req,
  input  logic [ADDR_W-1:0]     word_addr,
  input  logic                  invalidate,
  output logic                  word_ready,
  output logic                  word_valid,
  output logic [DATA_W-1:0]     word_data,
  output logic                  read_err,
  output logic                  flash_mem_read,
  output logic [ADDR_W-1:0]     flash_mem_address,
  output logic [DATA_W/8-1:0]   flash_mem_byteenable,
  input  logic                  flash_mem_waitrequest,
  input  logic [DATA_W-1:0]     flash_mem_readdata,
  input  logic                  flash_mem_readdatavalid
);
  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_HIT = HIT;
  localparam logic [2:0] S_ISSUE = ISSUE;
  localparam logic [2:0] S_WAIT = WAIT_DATA;
  localparam logic [2:0] S_DONE = DONE;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [2:0] state;
  logic [ADDR_W-1:0] addr, cache_addr;
  logic [DATA_W-1:0] cache_data;
  logic cache_valid, err;
  logic [CW-1:0] count;
  logic accept, hit, timed_out;
  assign word_ready = state == S_IDLE;
  assign word_valid = state == S_DONE;
  assign read_err = word_valid && err;
  assign flash_mem_read = state == S_ISSUE;
  assign flash_mem_address = addr;
  assign flash_mem_byteenable = '1;
  assign accept = word_req && word_ready;
  // invalidate in the accept cycle must force a miss, so it gates the compare directly
  assign hit = cache_valid && !invalidate && word_addr == cache_addr;
  assign timed_out = count == CW'(TIMEOUT_CYCLES);
  always_ff @(posedge fetch_clock) begin
    if (reset) begin
      state <= S_IDLE;
      addr <= '0;
      cache_addr <= '0;
      cache_data <= '0;
      cache_valid <= 1'b0;
      err <= 1'b0;
      count <= '0;
      word_data <= '0;
    end else begin
      if (invalidate) cache_valid <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          addr <= word_addr;
          err <= 1'b0;
          state <= hit ? S_HIT : S_ISSUE;
        end
        S_HIT: begin
          word_data <= cache_data;
          state <= S_DONE;
        end
        S_ISSUE: if (!flash_mem_waitrequest) begin
          count <= '0;
          state <= S_WAIT;
        end
        S_WAIT: if (flash_mem_readdatavalid) begin
          word_data <= flash_mem_readdata;
          cache_data <= flash_mem_readdata;
          cache_addr <= addr;
          cache_valid <= 1'b1;
          state <= S_DONE;
        end else if (timed_out) begin
          word_data <= '0;
          cache_valid <= 1'b0;
          err <= 1'b1;
          state <= S_DONE;
        end else begin
          count <= count + 1'b1;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
